// File: rtl/reg_file_param.sv
// Parametrised register file: two registered read ports with read-enable hold, optional zero entry,
// and a hardware clear sweep after reset. Define REGFILE_BYPASS_EN for same-edge write-to-read forwarding.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wr,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] rr1,
  input  logic [ADDR_W-1:0] rr2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              ready
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        state_q;
  logic [ADDR_W-1:0] clr_idx_q;
  logic [DATA_W-1:0] file_q [NUM_REGS];
  logic              wr_ok;
  logic [DATA_W-1:0] rv1;
  logic [DATA_W-1:0] rv2;

  // An address is backed by storage unless it is out of range or the hardwired zero entry.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a,
                                                 input logic             fwd,
                                                 input logic [ADDR_W-1:0] fwd_a,
                                                 input logic [DATA_W-1:0] fwd_d);
    if (!addr_ok(a)) return '0;
    if (fwd && (fwd_a == a)) return fwd_d;
    return file_q[a];
  endfunction

  assign wr_ok = (state_q == ST_RUN) && wren && addr_ok(wr);
  assign ready = (state_q == ST_RUN);

  always_comb begin
    rv1 = '0;
    rv2 = '0;
`ifdef REGFILE_BYPASS_EN
    rv1 = read_val(rr1, wr_ok, wr, wd);
    rv2 = read_val(rr2, wr_ok, wr, wd);
`else
    rv1 = read_val(rr1, 1'b0, wr, wd);
    rv2 = read_val(rr2, 1'b0, wr, wd);
`endif
  end

  // Sweep / run control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_idx_q <= clr_idx_q + ADDR_W'(1);
      if (clr_idx_q == ADDR_W'(NUM_REGS - 1)) begin
        state_q   <= ST_RUN;
        clr_idx_q <= '0;
      end
    end
  end

  // Storage: the reset branch is empty so contents are frozen, not cleared, while rst is high
  always_ff @(posedge clk or posedge rst) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        file_q[clr_idx_q] <= '0;
      end else if (wr_ok) begin
        file_q[wr] <= wd;
      end
    end
  end

  // Registered read ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1 <= '0;
      rd2 <= '0;
    end else if ((state_q == ST_RUN) && re) begin
      rd1 <= rv1;
      rd2 <= rv2;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Randomised bench for reg_file_param against an array-based reference model, plus directed corner cases.
module tb_reg_file_param;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZR       = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wren = 1'b0;
  logic [ADDR_W-1:0] wr = '0;
  logic [DATA_W-1:0] wd = '0;
  logic              re = 1'b0;
  logic [ADDR_W-1:0] rr1 = '0;
  logic [ADDR_W-1:0] rr2 = '0;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              ready;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DATA_W-1:0] mem [NUM_REGS];
  int                m_cnt;
  logic              m_ready;
  logic [DATA_W-1:0] e_rd1;
  logic [DATA_W-1:0] e_rd2;

  reg_file_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_REG(ZR)
  ) dut (
    .clk(clk), .rst(rst), .wren(wren), .wr(wr), .wd(wd), .re(re),
    .rr1(rr1), .rr2(rr2), .rd1(rd1), .rd2(rd2), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_value(input int a);
    if (ZR != 0 && a == 0) return '0;
    if (a >= NUM_REGS) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wren && int'(wr) == a) return wd;
`endif
    return mem[a];
  endfunction

  function automatic void model_reset();
    m_cnt   = 0;
    m_ready = 1'b0;
    e_rd1   = '0;
    e_rd2   = '0;
  endfunction

  function automatic void model_edge();
    if (!m_ready) begin
      m_cnt++;
      if (m_cnt == NUM_REGS) begin
        for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
        m_ready = 1'b1;
      end
    end else begin
      if (re) begin
        e_rd1 = m_value(int'(rr1));
        e_rd2 = m_value(int'(rr2));
      end
      if (wren && !(ZR != 0 && wr == '0) && int'(wr) < NUM_REGS) mem[int'(wr)] = wd;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("rd1", rd1, e_rd1);
    check("rd2", rd2, e_rd2);
    check("ready", ready, m_ready);
  endtask

  task automatic idle();
    wren = 1'b0;
    re   = 1'b0;
  endtask

  task automatic write(input int a, input logic [DATA_W-1:0] d);
    wren = 1'b1; wr = ADDR_W'(a); wd = d; re = 1'b0;
    step();
  endtask

  task automatic read(input int a1, input int a2);
    wren = 1'b0; re = 1'b1; rr1 = ADDR_W'(a1); rr2 = ADDR_W'(a2);
    step();
  endtask

  // Asserts rst between edges, checks the asynchronous drop, releases at the next falling edge.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check({tag, "_rd1"}, rd1, 0);
    check({tag, "_rd2"}, rd2, 0);
    check({tag, "_ready"}, ready, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sweep(input string tag);
    for (int e = 1; e <= NUM_REGS; e++) begin
      step();
      check(tag, ready, (e == NUM_REGS) ? 1 : 0);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 'x;
    model_reset();
    #1;
    check("por_rd1", rd1, 0);
    check("por_rd2", rd2, 0);
    check("por_ready", ready, 0);
    @(negedge clk);
    rst = 1'b0;

    // Sweep with writes attempted throughout: they must be ignored
    wren = 1'b1; wr = 5'd3; wd = 32'hFFFF_FFFF; re = 1'b1; rr1 = 5'd3;
    sweep("sweep_ready");
    read(3, 3);
    check("sweep_r3", rd1, 0);

    write(5, 32'hDEAD_BEEF);
    read(5, 5);
    check("basic_rd1", rd1, 32'hDEAD_BEEF);
    check("basic_rd2", rd2, 32'hDEAD_BEEF);

    write(0, 32'h1234_5678);
    read(0, 5);
    check("zero_reg", rd1, (ZR != 0) ? 32'h0 : 32'h1234_5678);

    write(7, 32'h11);
    wren = 1'b1; wr = 5'd7; wd = 32'h22; re = 1'b1; rr1 = 5'd7; rr2 = 5'd5;
    step();
`ifdef REGFILE_BYPASS_EN
    check("same_cycle", rd1, 32'h22);
`else
    check("same_cycle", rd1, 32'h11);
`endif
    read(7, 7);
    check("same_cycle_next", rd1, 32'h22);

    write(4, 32'hAAAA);
    read(4, 4);
    check("hold_pre", rd1, 32'hAAAA);
    re = 1'b0; wren = 1'b1; wr = 5'd4; wd = 32'hBBBB; rr1 = 5'd9;
    step();
    idle();
    step();
    check("hold_rd1", rd1, 32'hAAAA);
    read(4, 4);
    check("hold_release", rd1, 32'hBBBB);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      wren = ($urandom_range(0, 9) < 6);
      re   = ($urandom_range(0, 9) < 7);
      wr   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      wd   = $urandom;
      rr1  = ($urandom_range(0, 3) == 0) ? wr : ADDR_W'($urandom_range(0, NUM_REGS - 1));
      rr2  = ($urandom_range(0, 3) == 0) ? rr1 : ADDR_W'($urandom_range(0, NUM_REGS - 1));
      step();
    end

    // Reset part-way through a fresh sweep, at clr_idx = 10
    idle();
    @(posedge clk);
    #1;
    async_reset("rst_a");
    for (int e = 0; e < 10; e++) step();
    async_reset("rst_mid");
    sweep("resweep_ready");

    // Reset during normal operation
    write(9, 32'h55);
    read(9, 9);
    check("run_rd1", rd1, 32'h55);
    async_reset("rst_run");
    sweep("run_sweep_ready");
    for (int a = 0; a < NUM_REGS; a += 2) begin
      read(a, a + 1);
      check("cleared_rd1", rd1, 0);
      check("cleared_rd2", rd2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
